// File: rtl/stream_uart_tx.sv
// Byte-stream UART transmitter: FIFO-buffered AXI-stream input serialised as
// 8N1/8N2 frames, with optional CR/LF inserted after each tlast byte.
module stream_uart_tx #(
   parameter int CLK_FREQ_HZ = 16000000,
   parameter int BAUD        = 57600,
   parameter int DEPTH       = 16,
   parameter int STOP_BITS   = 1,
   parameter int EOL_MODE    = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [7:0]             i_tdata,
   input  logic                   i_tlast,
   input  logic                   i_tvalid,
   output logic                   o_tready,
   output logic                   o_uart_tx,
   output logic                   o_busy,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
   localparam int CW  = $clog2(DIV * STOP_BITS) + 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;

   localparam logic [CW-1:0] BIT_RL  = CW'(DIV - 1);
   localparam logic [CW-1:0] STOP_RL = CW'(STOP_BITS * DIV - 1);
   localparam logic [LW-1:0] FULL    = LW'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, EOL_CR, EOL_LF
   } state_t;

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic          rdy_q, push, pop;
   logic [8:0]    head;

   state_t        state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic          last_q, last_d;
   logic          eol_q, eol_d;
   logic          cr_q, cr_d;
   logic [2:0]    bit_q, bit_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;

   assign o_tready = rdy_q && (count != FULL);
   assign push     = i_tvalid && o_tready;
   assign o_level  = count;
   assign head     = mem[rd_ptr];
   assign tick     = (cnt_q == '0);
   assign o_busy   = (state_q != IDLE) || (count != '0);

   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= {i_tlast, i_tdata};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_q  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + LW'(1);
         else if (pop && !push) count <= count - LW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         last_q  <= 1'b0;
         eol_q   <= 1'b0;
         cr_q    <= 1'b0;
         bit_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         last_q  <= last_d;
         eol_q   <= eol_d;
         cr_q    <= cr_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
      end
   end

   // EOL_CR/EOL_LF act as the start bit of a fixed-byte frame
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      last_d    = last_q;
      eol_d     = eol_q;
      cr_d      = cr_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      pop       = 1'b0;
      o_uart_tx = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               sh_d    = head[7:0];
               last_d  = head[8];
               eol_d   = 1'b0;
               cr_d    = 1'b0;
               cnt_d   = BIT_RL;
               state_d = START;
            end
         end
         START, EOL_CR, EOL_LF: begin
            o_uart_tx = 1'b0;
            cnt_d     = cnt_q - CW'(1);
            if (tick) begin
               cnt_d   = BIT_RL;
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            o_uart_tx = sh_q[0];
            cnt_d     = cnt_q - CW'(1);
            if (tick) begin
               cnt_d = BIT_RL;
               sh_d  = {1'b0, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  cnt_d   = STOP_RL;
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            cnt_d = cnt_q - CW'(1);
            if (tick) begin
               cnt_d = BIT_RL;
               if (cr_q) begin
                  sh_d    = 8'h0A;
                  cr_d    = 1'b0;
                  state_d = EOL_LF;
               end else if (last_q && !eol_q && EOL_MODE == 2) begin
                  sh_d    = 8'h0D;
                  eol_d   = 1'b1;
                  cr_d    = 1'b1;
                  state_d = EOL_CR;
               end else if (last_q && !eol_q && EOL_MODE == 1) begin
                  sh_d    = 8'h0A;
                  eol_d   = 1'b1;
                  state_d = EOL_LF;
               end else if (count != '0) begin
                  pop     = 1'b1;
                  sh_d    = head[7:0];
                  last_d  = head[8];
                  eol_d   = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Directed bench: framing, FIFO flow control, EOL insertion,
// two-stop-bit timing, same-cycle push/pop and mid-frame reset.
`timescale 1ns/1ps
module tb_stream_uart_tx;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tdata;
   logic       tlast;
   logic [2:0] vld;
   logic [2:0] rdy, tx, busy;
   logic [4:0] lvl [3];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   logic [7:0] eol2_exp [4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
   logic [7:0] pp_d [5]     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stream_uart_tx #(
      .CLK_FREQ_HZ(16000000), .BAUD(1000000), .DEPTH(16),
      .STOP_BITS(1), .EOL_MODE(0)
   ) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
      .i_tvalid(vld[0]), .o_tready(rdy[0]), .o_uart_tx(tx[0]),
      .o_busy(busy[0]), .o_level(lvl[0])
   );

   stream_uart_tx #(
      .CLK_FREQ_HZ(16000000), .BAUD(1000000), .DEPTH(16),
      .STOP_BITS(2), .EOL_MODE(0)
   ) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
      .i_tvalid(vld[1]), .o_tready(rdy[1]), .o_uart_tx(tx[1]),
      .o_busy(busy[1]), .o_level(lvl[1])
   );

   stream_uart_tx #(
      .CLK_FREQ_HZ(16000000), .BAUD(1000000), .DEPTH(16),
      .STOP_BITS(1), .EOL_MODE(2)
   ) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata), .i_tlast(tlast),
      .i_tvalid(vld[2]), .o_tready(rdy[2]), .o_uart_tx(tx[2]),
      .o_busy(busy[2]), .o_level(lvl[2])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_frame(input logic [7:0] d, input int k);
      int s;
      s = k / DIV;
      if (s == 0) return 1'b0;
      if (s <= 8) return d[s-1];
      return 1'b1;
   endfunction

   task automatic push(input int w, input logic [7:0] d, input logic l);
      int g;
      g = 0;
      @(negedge clk);
      tdata  = d;
      tlast  = l;
      vld[w] = 1'b1;
      while (!rdy[w] && g < 2000) begin
         @(negedge clk);
         g++;
      end
      chk("push_ready", 32'(rdy[w]), 1);
      @(posedge clk);
      #1;
      vld = '0;
   endtask

   task automatic rx_byte(input int w, output logic [7:0] b, output int t0);
      int n;
      n  = 0;
      b  = '0;
      t0 = -1;
      @(negedge clk);
      while (tx[w] && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("rx_start_seen", 32'(tx[w]), 0);
      if (tx[w]) return;
      t0 = cyc;
      repeat (DIV / 2) @(negedge clk);
      chk("rx_start_mid", 32'(tx[w]), 0);
      for (int i = 0; i < 8; i++) begin
         repeat (DIV) @(negedge clk);
         b[i] = tx[w];
      end
      repeat (DIV) @(negedge clk);
      chk("rx_stop", 32'(tx[w]), 1);
   endtask

   task automatic watch_quiet(input int w, input int n, input string tag);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (!tx[w]) lows++;
      end
      chk(tag, 32'(lows), 0);
      chk({tag, "_busy"}, 32'(busy[w]), 0);
   endtask

   task automatic run_stream(input int n, input int seed, input logic chk_stall);
      logic [7:0] data [64];
      for (int i = 0; i < n; i++) data[i] = 8'((i * 37 + seed) & 255);
      fork
         begin : drv
            int   i, acc, g;
            logic hs, stalled, resumed;
            i = 0; acc = 0; g = 0;
            stalled = 1'b0;
            resumed = 1'b0;
            @(negedge clk);
            tdata  = data[0];
            tlast  = 1'b0;
            vld[0] = 1'b1;
            while (i < n && g < 20000) begin
               hs = rdy[0];
               if (!hs && !stalled) begin
                  stalled = 1'b1;
                  if (chk_stall) begin
                     chk("burst_acc", 32'(acc), 17);
                     chk("burst_full_lvl", 32'(lvl[0]), 16);
                  end
               end
               if (hs && stalled && !resumed) begin
                  resumed = 1'b1;
                  if (chk_stall) chk("burst_pop_lvl", 32'(lvl[0]), 15);
               end
               @(negedge clk);
               g++;
               if (hs) begin
                  i++;
                  acc++;
                  if (i < n) tdata = data[i];
               end
            end
            vld[0] = 1'b0;
            chk("stream_all_pushed", 32'(i), 32'(n));
         end
         begin : mon
            int         tp, t;
            logic [7:0] b;
            tp = -1;
            for (int k = 0; k < n; k++) begin
               rx_byte(0, b, t);
               chk($sformatf("stream_b%0d", k), 32'(b), 32'(data[k]));
               if (k > 0) chk($sformatf("stream_gap%0d", k), t - tp, 160);
               tp = t;
            end
         end
      join
   endtask

   initial begin
      logic [7:0] b;
      int         t, tp;

      rst_n = 1'b0;
      tdata = '0;
      tlast = 1'b0;
      vld   = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx[0]), 1);
      chk("rst_tready", 32'(rdy[0]), 0);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_level", 32'(lvl[0]), 0);
      rst_n = 1'b1;
      #1;
      chk("rel_tready_lo", 32'(rdy[0]), 0);
      @(negedge clk);
      chk("rel_tready_hi", 32'(rdy[0]), 1);

      // single 0xA5 frame, cycle-exact
      push(0, 8'hA5, 1'b0);
      @(negedge clk);
      chk("lat_tx_hi", 32'(tx[0]), 1);
      chk("lat_level1", 32'(lvl[0]), 1);
      for (int k = 0; k < 161; k++) begin
         @(negedge clk);
         if (k == 0) chk("lat_level0", 32'(lvl[0]), 0);
         chk($sformatf("a5_tx%0d", k), 32'(tx[0]), 32'(exp_frame(8'hA5, k)));
         chk($sformatf("a5_busy%0d", k), 32'(busy[0]), (k < 160) ? 1 : 0);
      end

      // CR LF insertion
      push(2, 8'h4F, 1'b0);
      push(2, 8'h4B, 1'b1);
      tp = -1;
      for (int i = 0; i < 4; i++) begin
         rx_byte(2, b, t);
         chk($sformatf("eol2_byte%0d", i), 32'(b), 32'(eol2_exp[i]));
         if (i > 0) chk($sformatf("eol2_gap%0d", i), t - tp, 160);
         tp = t;
      end
      watch_quiet(2, 400, "eol2_quiet");

      // no EOL
      push(0, 8'h4F, 1'b0);
      push(0, 8'h4B, 1'b1);
      rx_byte(0, b, tp);
      chk("eol0_byte0", 32'(b), 32'h4F);
      rx_byte(0, b, t);
      chk("eol0_byte1", 32'(b), 32'h4B);
      chk("eol0_gap", t - tp, 160);
      watch_quiet(0, 400, "eol0_quiet");

      // two stop bits
      push(1, 8'h00, 1'b0);
      push(1, 8'hFF, 1'b0);
      rx_byte(1, b, tp);
      chk("s2_byte0", 32'(b), 32'h00);
      rx_byte(1, b, t);
      chk("s2_byte1", 32'(b), 32'hFF);
      chk("s2_gap", t - tp, 176);
      repeat (23) @(negedge clk);
      chk("s2_end_tx", 32'(tx[1]), 1);
      chk("s2_end_busy", 32'(busy[1]), 1);
      @(negedge clk);
      chk("s2_idle_busy", 32'(busy[1]), 0);

      // burst of 20 into a 16-deep FIFO
      run_stream(20, 3, 1'b1);
      repeat (20) @(negedge clk);

      // push and pop in the same cycle at level 3
      for (int i = 0; i < 4; i++) push(0, pp_d[i], 1'b0);
      repeat (158) @(negedge clk);
      chk("pp_pre_lvl", 32'(lvl[0]), 3);
      chk("pp_pre_tx", 32'(tx[0]), 1);
      tdata  = pp_d[4];
      tlast  = 1'b0;
      vld[0] = 1'b1;
      @(posedge clk);
      #1;
      vld = '0;
      @(negedge clk);
      chk("pp_lvl", 32'(lvl[0]), 3);
      chk("pp_newframe", 32'(tx[0]), 0);
      for (int i = 1; i < 5; i++) begin
         rx_byte(0, b, t);
         chk($sformatf("pp_byte%0d", i), 32'(b), 32'(pp_d[i]));
      end
      repeat (20) @(negedge clk);

      // pointer wrap over 3*DEPTH bytes
      run_stream(48, 101, 1'b0);
      repeat (20) @(negedge clk);

      // reset during bit 4 with 5 bytes queued
      for (int i = 0; i < 6; i++) push(0, 8'h0F ^ 8'(i), 1'b0);
      repeat (82) @(negedge clk);
      chk("rst_pre_lvl", 32'(lvl[0]), 5);
      chk("rst_pre_tx", 32'(tx[0]), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", 32'(tx[0]), 1);
      chk("rst_mid_lvl", 32'(lvl[0]), 0);
      chk("rst_mid_rdy", 32'(rdy[0]), 0);
      chk("rst_mid_busy", 32'(busy[0]), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_rdy_lo", 32'(rdy[0]), 0);
      @(negedge clk);
      chk("rst_rel_rdy_hi", 32'(rdy[0]), 1);
      watch_quiet(0, 400, "rst_quiet");
      chk("rst_post_lvl", 32'(lvl[0]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_uart_tx.md
# stream_uart_tx

Parametrised successor to the byte emitter that carries corescorecore's AXI-stream output off-chip. Accepts an 8-bit AXI-stream with tlast, buffers it in an internal FIFO, and serialises each byte as a UART 8N1/8N2 frame at a baud rate derived from parameters. Optionally inserts an end-of-line sequence after every tlast byte. Sits between corescorecore and the board's UART TX pin in every corescore top.

## Interface
- CLK_FREQ_HZ, 16000000, i_clk frequency in Hz
- BAUD, 57600, line rate; divider DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD, DIV >= 2 required
- DEPTH, 16, FIFO entries; power of two, >= 2
- STOP_BITS, 1, stop bits per frame; 1 or 2
- EOL_MODE, 0, 0 = none, 1 = LF (0x0A), 2 = CR LF (0x0D 0x0A) after each tlast byte

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_tdata  in  8  stream byte
- i_tlast  in  1  last byte of message
- i_tvalid  in  1  byte valid
- o_tready  out  1  FIFO can accept
- o_uart_tx  out  1  serial line, idle high
- o_busy  out  1  FIFO non-empty or frame in progress
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Handshake: transfer on rising edge with i_tvalid && o_tready. FIFO stores {tlast, tdata}.
- o_tready = rdy_q && (o_level != DEPTH); rdy_q clears on reset, sets on first edge after release. Not dependent on same-cycle pop.
- Simultaneous push and pop: level unchanged, both take effect.
- FSM states: IDLE, START, DATA, STOP, EOL_CR, EOL_LF (EOL states reuse START/DATA/STOP framing with a fixed byte).
- IDLE: o_uart_tx=1. If level != 0, pop head into shift register, latch tlast, go START.
- START: tx=0 for DIV cycles -> DATA.
- DATA: 8 bits, LSB first, DIV cycles each, 3-bit bit counter -> STOP.
- STOP: tx=1 for STOP_BITS*DIV cycles. Then: if latched tlast and EOL_MODE=2 and current byte is not an EOL byte -> frame 0x0D, then 0x0A; EOL_MODE=1 -> frame 0x0A; else if level != 0 pop and go START directly (no idle gap); else IDLE.
- EOL bytes never enter the FIFO and do not affect o_level. FIFO continues accepting during EOL frames.
- Baud counter: down-counter of width $clog2(DIV*STOP_BITS)+1, reloaded on every bit boundary; no accumulated drift.
- o_busy = (state != IDLE) || (o_level != 0).

## Timing
- Reset (async assert, sync-effective deassert): o_uart_tx=1, o_tready=0, o_busy=0, o_level=0; FIFO pointers cleared, FSM IDLE.
- Reset mid-frame: line goes high immediately, partial frame and FIFO contents discarded, no EOL emitted.
- Latency: byte accepted at edge N into empty FIFO with FSM IDLE -> o_uart_tx falls at edge N+1 (level reads 1 after N, pop at N+1, level 0 after N+1).
- Frame length: (9 + STOP_BITS) * DIV cycles exactly; back-to-back frames contiguous.
- Full FIFO: o_tready low; first pop raises o_tready on the next cycle.
- Pointers wrap modulo DEPTH; occupancy counter distinguishes full from empty.

## Test plan
- CLK_FREQ_HZ=16000000, BAUD=1000000 (DIV=16), push 0xA5 -> line low at edge N+1 for 16 cycles, bits 1,0,1,0,0,1,0,1 at 16 cycles each, high 16 cycles; o_busy drops after 160 cycles.
- Burst of 20 bytes with DEPTH=16, tvalid held -> 17 accepted before first stall (one popped immediately), o_tready low while level=16, all 20 bytes emitted in order with no inter-frame gap.
- EOL_MODE=2, push 'O','K'(tlast) -> line carries 0x4F, 0x4B, 0x0D, 0x0A; EOL_MODE=0 -> only 0x4F, 0x4B.
- STOP_BITS=2, push 0x00 then 0xFF -> stop period 32 cycles, frame 176 cycles, second start bit at cycle 176 after first.
- Assert i_rst_n low at bit 4 of a frame with 5 bytes queued -> o_uart_tx=1 and o_level=0 immediately; after release o_tready=0 for one cycle, then 1; no residual bytes transmitted.
- Push and pop in same cycle at level 3 -> o_level stays 3; pointer wrap exercised over 3*DEPTH bytes with data integrity checked.
